// File: rtl/sm83_pkg.sv
// ---------------------------------------------------------------------------
// sm83_pkg
// Shared types and constants for the sm83 memory arbiter.
//   arb_state_t : arbiter / OAM DMA state machine states
//   rd_src_t    : source of the byte returned to the CPU one cycle after
//                 it presents an address
//   HRAM_BASE/HRAM_TOP : inclusive bounds of the internal high RAM window
// ---------------------------------------------------------------------------
package sm83_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_HRAM,
        SRC_REG,
        SRC_BLOCKED
    } rd_src_t;

    localparam logic [15:0] HRAM_BASE = 16'hFF80;
    localparam logic [15:0] HRAM_TOP  = 16'hFFFE;

    function automatic logic in_hram(input logic [15:0] addr);
        return (addr >= HRAM_BASE) && (addr <= HRAM_TOP);
    endfunction

endpackage

// File: rtl/hram.sv
// ---------------------------------------------------------------------------
// hram
// 127 x 8 synchronous RAM backing the CPU's high RAM window (0xFF80-0xFFFE).
// Writes land on the rising edge; reads are registered, so data appears on
// rdata the cycle after the address is presented. Contents are not reset.
// Ports:
//   clk   : system clock
//   we    : write enable
//   re    : read enable (read register only updates when set)
//   addr  : word address 0..126
//   wdata : write data
//   rdata : registered read data
// ---------------------------------------------------------------------------
module hram (
    input  logic       clk,
    input  logic       we,
    input  logic       re,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:126];

    // Address 127 maps to 0xFFFF, which is outside the window, so the
    // enables are only ever raised for in-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Owns the single-port system memory bus between the sm83 core and memory,
// and contains the OAM DMA engine. A CPU write to DMA_REG latches a source
// page and copies DMA_LEN bytes from {page,8'h00} to DMA_DEST. While a
// transfer runs the CPU is locked out of main memory but keeps full access
// to the internal HRAM.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   cpu_addr   : CPU address
//   cpu_d_out  : CPU write data
//   cpu_write  : CPU write strobe
//   cpu_d_in   : read data to CPU, valid the cycle after cpu_addr
//   mem_addr   : memory address
//   mem_d_out  : memory write data
//   mem_write  : memory write strobe
//   mem_d_in   : memory read data, valid one cycle after mem_addr
//   dma_active : high from START through the last WRITE of a transfer
// ---------------------------------------------------------------------------
module mem_arbiter
    import sm83_pkg::*;
#(
    parameter int          DMA_LEN     = 160,
    parameter logic [15:0] DMA_DEST    = 16'hFE00,
    parameter logic [15:0] DMA_REG     = 16'hFF46,
    parameter int          START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    output logic [7:0]  cpu_d_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_write,
    input  logic [7:0]  mem_d_in,
    output logic        dma_active
);

    // START always occupies at least one cycle, even for START_DELAY=0.
    localparam int            START_CYC = (START_DELAY < 1) ? 1 : START_DELAY;
    localparam int            DW        = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam logic [DW-1:0] DLY_LAST  = DW'(START_CYC - 1);
    localparam logic [7:0]    IDX_LAST  = 8'(DMA_LEN - 1);

    arb_state_t    state;
    rd_src_t       rd_src;
    logic [7:0]    page;
    logic [7:0]    idx;
    logic [DW-1:0] dly_cnt;

    logic          hit_hram;
    logic          hit_reg;
    logic          reg_write;
    logic [7:0]    hram_rdata;

    assign hit_hram  = in_hram(cpu_addr);
    assign hit_reg   = !hit_hram && (cpu_addr == DMA_REG);
    assign reg_write = hit_reg && cpu_write;

    hram u_hram (
        .clk   (clk),
        .we    (cpu_write && hit_hram),
        .re    (hit_hram),
        .addr  (cpu_addr[6:0]),
        .wdata (cpu_d_out),
        .rdata (hram_rdata)
    );

    // DMA state machine. A page-register write restarts the copy from
    // index 0 regardless of the current state, including the final WRITE
    // (that last byte still lands this cycle, then START follows).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dma_active <= 1'b0;
            page       <= 8'h00;
            idx        <= 8'h00;
            dly_cnt    <= '0;
        end else if (reg_write) begin
            page       <= cpu_d_out;
            state      <= START;
            dma_active <= 1'b1;
            idx        <= 8'h00;
            dly_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                end
                START: begin
                    if (dly_cnt == DLY_LAST) begin
                        state <= READ;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                READ: begin
                    state <= WRITE;
                end
                WRITE: begin
                    idx <= idx + 8'h01;
                    if (idx == IDX_LAST) begin
                        state      <= IDLE;
                        dma_active <= 1'b0;
                    end else begin
                        state <= READ;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

    // Remember where this cycle's read is served from so the returned byte
    // lines up with the one-cycle latency of memory and HRAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_src <= SRC_BLOCKED;
        end else if (hit_hram) begin
            rd_src <= SRC_HRAM;
        end else if (hit_reg) begin
            rd_src <= SRC_REG;
        end else if (state == IDLE) begin
            rd_src <= SRC_MEM;
        end else begin
            rd_src <= SRC_BLOCKED;
        end
    end

    // Memory bus: CPU pass-through when idle, DMA-owned otherwise. The
    // source index wraps inside the page; the destination is a plain add.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_d_out = cpu_d_out;
        mem_write = 1'b0;
        case (state)
            IDLE: begin
                mem_write = cpu_write && !hit_hram && !hit_reg;
            end
            READ: begin
                mem_addr = {page, idx};
            end
            WRITE: begin
                mem_addr  = DMA_DEST + {8'h00, idx};
                mem_d_out = mem_d_in;
                mem_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        case (rd_src)
            SRC_MEM:  cpu_d_in = mem_d_in;
            SRC_HRAM: cpu_d_in = hram_rdata;
            SRC_REG:  cpu_d_in = page;
            default:  cpu_d_in = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a 64 KiB one-cycle-latency memory
// model. Inputs change 2-3 time units after the rising edge; outputs are
// checked in that same window, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_d_out = 8'h00;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_write;
    logic [7:0]  mem_d_in;
    logic        dma_active;

    logic [7:0]  mem_model [0:65535];

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int act_count = 0;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_d_out  (cpu_d_out),
        .cpu_write  (cpu_write),
        .cpu_d_in   (cpu_d_in),
        .mem_addr   (mem_addr),
        .mem_d_out  (mem_d_out),
        .mem_write  (mem_write),
        .mem_d_in   (mem_d_in),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_write) begin
            mem_model[mem_addr] <= mem_d_out;
        end
        mem_d_in <= mem_model[mem_addr];
    end

    // Running counts of memory write strobes and dma_active-high cycles.
    always @(posedge clk) begin
        if (mem_write) begin
            wr_count <= wr_count + 1;
        end
        if (dma_active) begin
            act_count <= act_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic w);
        cpu_addr  = a;
        cpu_d_out = d;
        cpu_write = w;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        while (dma_active && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 16'(dma_active), 16'h0000);
    endtask

    initial begin
        int s_wr;
        int s_act;

        // Reset state
        applyStimulus(16'h1234, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("rst_dma_active", 16'(dma_active), 16'h0000);
        checkOutput("rst_cpu_d_in", 16'(cpu_d_in), 16'h00FF);
        checkOutput("rst_mem_write", 16'(mem_write), 16'h0000);
        checkOutput("rst_mem_addr", mem_addr, 16'h1234);
        rst = 1'b0;

        // Idle pass-through write then read
        $display("[TB] idle pass-through");
        applyStimulus(16'hC000, 8'h5A, 1'b1);
        checkOutput("pt_mem_write", 16'(mem_write), 16'h0001);
        checkOutput("pt_mem_addr", mem_addr, 16'hC000);
        checkOutput("pt_mem_d_out", 16'(mem_d_out), 16'h005A);
        s_wr = wr_count;
        tick();
        applyStimulus(16'hC000, 8'h00, 1'b0);
        checkOutput("pt_read_no_write", 16'(mem_write), 16'h0000);
        tick();
        checkOutput("pt_read_data", 16'(cpu_d_in), 16'h005A);
        checkOutput("pt_write_pulses", 16'(wr_count - s_wr), 16'h0001);

        // Preload two source pages through the pass-through path
        for (int i = 0; i < 160; i++) begin
            applyStimulus(16'hC000 + 16'(i), 8'(i) ^ 8'h3C, 1'b1);
            tick();
            applyStimulus(16'hD000 + 16'(i), 8'(i) ^ 8'hA5, 1'b1);
            tick();
        end
        applyStimulus(16'h0000, 8'h00, 1'b0);

        // Full DMA with lockout and HRAM traffic mid-transfer
        $display("[TB] full DMA from page C0");
        applyStimulus(16'hFF46, 8'hC0, 1'b1);
        checkOutput("dma_not_yet_active", 16'(dma_active), 16'h0000);
        checkOutput("reg_write_no_mem", 16'(mem_write), 16'h0000);
        tick();
        s_wr  = wr_count;
        s_act = act_count;
        applyStimulus(16'h0000, 8'h00, 1'b0);
        checkOutput("dma_rise", 16'(dma_active), 16'h0001);
        tick();
        tick();
        applyStimulus(16'hC000, 8'h00, 1'b0);
        tick();
        checkOutput("lockout_read", 16'(cpu_d_in), 16'h00FF);
        applyStimulus(16'hD000, 8'h11, 1'b1);
        tick();
        applyStimulus(16'hFF90, 8'h77, 1'b1);
        tick();
        applyStimulus(16'hFF90, 8'h00, 1'b0);
        tick();
        checkOutput("hram_during_dma", 16'(cpu_d_in), 16'h0077);
        checkOutput("hram_dma_still_active", 16'(dma_active), 16'h0001);
        applyStimulus(16'h0000, 8'h00, 1'b0);
        waitIdle("dma_done_timeout", 400);
        checkOutput("dma_active_cycles", 16'(act_count - s_act), 16'd321);
        checkOutput("dma_write_pulses", 16'(wr_count - s_wr), 16'd160);
        for (int i = 0; i < 160; i++) begin
            checkOutput($sformatf("dma_copy_%0d", i), 16'(mem_model[16'hFE00 + 16'(i)]), 16'(8'(i) ^ 8'h3C));
        end
        checkOutput("lockout_write_dropped", 16'(mem_model[16'hD000]), 16'h00A5);

        // Restart 50 cycles into a transfer
        $display("[TB] restart from page D0");
        applyStimulus(16'hFF46, 8'hC0, 1'b1);
        tick();
        applyStimulus(16'h0000, 8'h00, 1'b0);
        for (int i = 0; i < 49; i++) begin
            tick();
        end
        applyStimulus(16'hFF46, 8'hD0, 1'b1);
        checkOutput("restart_active_before", 16'(dma_active), 16'h0001);
        tick();
        s_wr  = wr_count;
        s_act = act_count;
        applyStimulus(16'h0000, 8'h00, 1'b0);
        waitIdle("restart_done_timeout", 400);
        checkOutput("restart_active_cycles", 16'(act_count - s_act), 16'd321);
        checkOutput("restart_write_pulses", 16'(wr_count - s_wr), 16'd160);
        for (int i = 0; i < 160; i++) begin
            checkOutput($sformatf("restart_copy_%0d", i), 16'(mem_model[16'hFE00 + 16'(i)]), 16'(8'(i) ^ 8'hA5));
        end
        applyStimulus(16'hFF46, 8'h00, 1'b0);
        tick();
        checkOutput("reg_readback", 16'(cpu_d_in), 16'h00D0);

        // Restart coinciding with the final WRITE
        $display("[TB] restart on final write");
        applyStimulus(16'hFF46, 8'hC0, 1'b1);
        tick();
        s_wr = wr_count;
        applyStimulus(16'h0000, 8'h00, 1'b0);
        for (int i = 0; i < 320; i++) begin
            tick();
        end
        checkOutput("final_write_strobe", 16'(mem_write), 16'h0001);
        checkOutput("final_write_addr", mem_addr, 16'hFE9F);
        applyStimulus(16'hFF46, 8'hD0, 1'b1);
        tick();
        s_act = act_count;
        applyStimulus(16'h0000, 8'h00, 1'b0);
        checkOutput("final_restart_active", 16'(dma_active), 16'h0001);
        checkOutput("final_write_pulses", 16'(wr_count - s_wr), 16'd160);
        waitIdle("final_restart_timeout", 400);
        checkOutput("final_restart_cycles", 16'(act_count - s_act), 16'd321);

        // Reset in the middle of a transfer (READ of idx 40)
        $display("[TB] reset mid-transfer");
        applyStimulus(16'hFF46, 8'hC0, 1'b1);
        tick();
        applyStimulus(16'h0000, 8'h00, 1'b0);
        for (int i = 0; i < 81; i++) begin
            tick();
        end
        checkOutput("pre_reset_read_addr", mem_addr, 16'hC028);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_dma_active", 16'(dma_active), 16'h0000);
        checkOutput("mid_rst_cpu_d_in", 16'(cpu_d_in), 16'h00FF);
        s_wr = wr_count;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        checkOutput("mid_rst_no_writes", 16'(wr_count - s_wr), 16'h0000);
        checkOutput("mid_rst_last_copied", 16'(mem_model[16'hFE27]), 16'(8'h27 ^ 8'h3C));
        checkOutput("mid_rst_not_copied", 16'(mem_model[16'hFE28]), 16'(8'h28 ^ 8'hA5));
        applyStimulus(16'hFF46, 8'h00, 1'b0);
        tick();
        checkOutput("mid_rst_reg_cleared", 16'(cpu_d_in), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the sm83 core and the single-port system memory.
- Owns the memory bus and contains the OAM DMA engine: a CPU write to 0xFF46 copies DMA_LEN bytes from {page,8'h00} to DMA_DEST.
- While DMA runs, the CPU is locked out of main memory and keeps access only to an internal 127-byte HRAM (0xFF80-0xFFFE).
- Single clock domain; the memory model has one-cycle read latency.

Parameters:
- DMA_LEN, 160: bytes copied per transfer (1..256).
- DMA_DEST, 16'hFE00: destination base address (OAM).
- DMA_REG, 16'hFF46: address of the DMA source-page register.
- START_DELAY, 1: idle cycles between the FF46 write and the first DMA read.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address.
- cpu_d_out  in  8  CPU write data.
- cpu_write  in  1  CPU write strobe.
- cpu_d_in  out  8  read data to CPU; valid the cycle after cpu_addr is presented.
- mem_addr  out  16  memory address.
- mem_d_out  out  8  memory write data.
- mem_write  out  1  memory write strobe.
- mem_d_in  in  8  memory read data; valid one cycle after mem_addr.
- dma_active  out  1  high while a transfer is in progress (START through last WRITE).

Behaviour:
- Reset values:
  - state=IDLE, dma_active=0, page register=8'h00, byte index=0.
  - mem_write=0, mem_addr=cpu_addr (pass-through), cpu_d_in=8'hFF.
  - HRAM contents are not reset.
- Address decode, combinational on cpu_addr:
  - HRAM: 0xFF80-0xFFFE.
  - REG: DMA_REG.
  - MEM: everything else.
- HRAM access (hram sub-module):
  - Always serviced, even during DMA.
  - Write lands on the rising edge.
  - Read data appears on cpu_d_in the next cycle.
- REG access:
  - Read returns the page register the next cycle.
  - Write latches cpu_d_out[7:0] into the page register and forces state=START and byte index=0, even if a transfer is active (restart, no abort).
- MEM access when IDLE: pure pass-through.
  - mem_addr=cpu_addr, mem_d_out=cpu_d_out, mem_write=cpu_write.
  - cpu_d_in=mem_d_in the next cycle.
- MEM access when not IDLE:
  - CPU writes are dropped (never reach mem_write).
  - CPU reads return 8'hFF the next cycle.
- cpu_d_in source select:
  - Registered 2-bit select {MEM, HRAM, REG, BLOCKED}, captured each cycle from the current decode and state.
  - cpu_d_in is muxed from that select.
- State machine: IDLE -> START -> READ <-> WRITE -> IDLE.
  - START: waits START_DELAY cycles; the bus stays owned by the arbiter with mem_write=0 and mem_addr=cpu_addr.
  - READ: mem_addr={page, idx}, mem_write=0.
  - WRITE: mem_addr=DMA_DEST+idx, mem_d_out=mem_d_in (byte fetched in READ), mem_write=1.
  - After WRITE, idx increments. If idx==DMA_LEN-1 the machine goes to IDLE, otherwise to READ.
- Timing and width rules:
  - Transfer length is 2*DMA_LEN cycles after START; 320 for the default.
  - idx is 8 bits. Source address wraps within the page (no carry into the page byte).
  - Destination address is a 16-bit add with no wrap check.
- Simultaneous events:
  - FF46 write in the same cycle as the final WRITE: the restart wins and the next state is START.
  - A CPU HRAM write and a DMA WRITE in the same cycle both complete (separate resources).
- Reset mid-transfer: returns to IDLE on that edge and the partial copy is abandoned. The page register is cleared.
- Page values >= 0xFE are legal and copied verbatim; no source remapping.

Decomposition:
- Shared package (sm83_pkg), holding:
  - arb_state_t enum {IDLE, START, READ, WRITE}.
  - rd_src_t enum {SRC_MEM, SRC_HRAM, SRC_REG, SRC_BLOCKED}.
  - HRAM_BASE/HRAM_TOP constants.
- One sub-module, hram: 127x8 synchronous RAM with a registered read port.

Test Plan:
- Idle pass-through: CPU writes 8'h5A to 0xC000, then reads it -> mem_write pulses once with mem_addr=0xC000; cpu_d_in=8'h5A one cycle after the read address.
- Full DMA: preload 0xC000-0xC09F with i^8'h3C, CPU writes 8'hC0 to 0xFF46 -> dma_active rises the next cycle and stays high 1+320 cycles; 0xFE00-0xFE9F match the source; 160 mem_write pulses total.
- Lockout: during DMA, CPU reads 0xC000 -> cpu_d_in=8'hFF; CPU writes 8'h11 to 0xD000 -> 0xD000 unchanged.
- HRAM during DMA: CPU writes 8'h77 to 0xFF90 then reads it mid-transfer -> cpu_d_in=8'h77; DMA byte count is unaffected.
- Restart and readback: write 0xC0 to FF46, then after 50 cycles write 0xD0 -> copy restarts from 0xD000 at idx 0, ends 321 cycles after the second write; a read of 0xFF46 returns 8'hD0.
- Reset mid-transfer: assert rst for 1 cycle at idx 40 -> dma_active=0 and cpu_d_in=8'hFF the next cycle, with no further mem_write pulses; a read of FF46 returns 8'h00.
